// File: rtl/regfile_debug_scanner_if.sv
// Output word stream of the register-file debug scanner: valid/ready handshake
// carrying the register index, its captured value and an end-of-dump flag.
interface regfile_debug_scanner_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, index, data, last, input ready);
  modport slave  (input valid, index, data, last, output ready);
endinterface

// File: rtl/regfile_debug_scanner.sv
// Reads the CPU register file through its debug port and streams the values out,
// either every register in ascending order or a single selected one.
module regfile_debug_scanner #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    single,
  input  logic [ADDR_W-1:0]       sel_reg,
  output logic [ADDR_W-1:0]       debug_input,
  input  logic [DATA_W-1:0]       debug_output,
  regfile_debug_scanner_if.master out,
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StSend  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              single_q, single_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] oidx_q, oidx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    single_d = single_q;
    valid_d  = valid_q;
    oidx_d   = oidx_q;
    data_d   = data_q;
    last_d   = last_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d    = single ? sel_reg : '0;
          single_d = single;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        // Address has been stable for a full cycle, so the read data is settled.
        data_d  = debug_output;
        oidx_d  = idx_q;
        last_d  = single_q || (idx_q == LastIdx);
        valid_d = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (valid_q && out.ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      single_q <= 1'b0;
      valid_q  <= 1'b0;
      oidx_q   <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      single_q <= single_d;
      valid_q  <= valid_d;
      oidx_q   <= oidx_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  // The scan index register doubles as the registered debug address.
  assign debug_input = idx_q;
  assign out.valid   = valid_q;
  assign out.index   = oidx_q;
  assign out.data    = data_q;
  assign out.last    = last_q;
  assign busy        = (state_q == StFetch) || (state_q == StSend);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_regfile_debug_scanner.sv
// Randomised self-checking bench for regfile_debug_scanner with a register-file model.
module tb_regfile_debug_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        single = 1'b0;
  logic [4:0]  sel_reg = '0;
  logic [4:0]  debug_input;
  logic [31:0] debug_output;
  logic        busy, done;
  logic [31:0] regs [32];

  regfile_debug_scanner_if #(.ADDR_W(5), .DATA_W(32)) out_if ();

  regfile_debug_scanner #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .single       (single),
    .sel_reg      (sel_reg),
    .debug_input  (debug_input),
    .debug_output (debug_output),
    .out          (out_if),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  assign debug_output = regs[debug_input];

  int n_tests = 0;
  int n_fail  = 0;

  // Observations gathered by run(); each test compares them to its own expectations.
  int          got_idx[$];
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cyc[$];
  int          done_cyc[$];
  logic [31:0] stall_d[$];
  int          stall_i[$];
  int          stall_g[$];
  int          drop_cnt, hold_cnt, overlap_cnt, late_busy;
  bit          timed_out;
  bit          obs_busy1;
  int          obs_dbg1;
  logic [31:0] exp_d[32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[0] = 32'h0;
  endtask

  task automatic run(input bit sgl, input logic [4:0] sel, input bit rnd, input bit stall7,
                     input bit inj, input bit wr);
    int rel, after_done, stall_left;
    bit prev_valid, prev_hs, hs, wr5;
    logic [31:0] prev_data;
    logic [4:0]  prev_idx;
    logic        prev_last;
    got_idx.delete(); got_data.delete(); got_last.delete(); got_cyc.delete();
    done_cyc.delete(); stall_d.delete(); stall_i.delete(); stall_g.delete();
    drop_cnt = 0; hold_cnt = 0; overlap_cnt = 0; late_busy = 0; timed_out = 1;
    rel = 0; after_done = -1; stall_left = -1; prev_valid = 0; prev_hs = 0; wr5 = 0;
    prev_data = '0; prev_idx = '0; prev_last = 0;
    start = 1'b1; single = sgl; sel_reg = sel; out_if.ready = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      step();
      rel++;
      start = inj && (rel == 1 || rel == 2);
      if (rel == 1) begin obs_busy1 = busy; obs_dbg1 = int'(debug_input); end
      if (wr && out_if.valid && out_if.index == 5'd19) regs[20] = 32'hDEAD_BEEF;
      if (wr5) begin regs[5] = 32'hBAD0_0005; wr5 = 0; end
      if (stall7 && out_if.valid && out_if.index == 5'd7 && stall_left < 0) stall_left = 5;
      if (stall_left > 0) begin
        out_if.ready = 1'b0;
        stall_left--;
        stall_d.push_back(out_if.data);
        stall_i.push_back(int'(out_if.index));
        stall_g.push_back(int'(debug_input));
      end else begin
        out_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (prev_valid && !prev_hs) begin
        if (!out_if.valid) drop_cnt++;
        else if (out_if.data !== prev_data || out_if.index !== prev_idx ||
                 out_if.last !== prev_last) hold_cnt++;
      end
      if (done && busy) overlap_cnt++;
      if (after_done > 0 && (busy || out_if.valid || done)) late_busy++;
      if (done) begin
        done_cyc.push_back(rel);
        if (after_done < 0) after_done = 0;
        if (inj) start = 1'b1;
      end
      hs = out_if.valid && out_if.ready;
      if (hs) begin
        got_idx.push_back(int'(out_if.index));
        got_data.push_back(out_if.data);
        got_last.push_back(out_if.last);
        got_cyc.push_back(rel);
        if (wr && out_if.index == 5'd5) wr5 = 1;
      end
      prev_valid = out_if.valid; prev_hs = hs;
      prev_data = out_if.data; prev_idx = out_if.index; prev_last = out_if.last;
      if (after_done >= 0) begin
        if (after_done == 4) begin timed_out = 0; break; end
        after_done++;
      end
    end
    start = 1'b0;
    out_if.ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_if.ready = 1'b0;
    step(); step();
    rst = 1'b0;
    n_tests++; if (debug_input !== 5'd0) begin n_fail++; $display("FAIL reset_debug_input: got %0h expected 0", debug_input); end
    n_tests++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_if.valid); end
    n_tests++; if (out_if.index !== 5'd0) begin n_fail++; $display("FAIL reset_index: got %0h expected 0", out_if.index); end
    n_tests++; if (out_if.data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", out_if.data); end
    n_tests++; if (out_if.last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", out_if.last); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
  endtask

  task automatic test_full_dump();
    preload();
    for (int i = 0; i < 32; i++) exp_d[i] = regs[i];
    run(0, 5'd0, 0, 0, 0, 0);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL full_timeout: got 1 expected 0"); end
    n_tests++; if (got_idx.size() != 32) begin n_fail++; $display("FAIL full_count: got %0d expected 32", got_idx.size()); end
    n_tests++; if (obs_busy1 !== 1'b1) begin n_fail++; $display("FAIL full_busy_c1: got %b expected 1", obs_busy1); end
    n_tests++; if (obs_dbg1 != 0) begin n_fail++; $display("FAIL full_dbg_c1: got %0d expected 0", obs_dbg1); end
    for (int k = 0; k < got_idx.size() && k < 32; k++) begin
      n_tests++; if (got_idx[k] != k) begin n_fail++; $display("FAIL full_idx[%0d]: got %0d expected %0d", k, got_idx[k], k); end
      n_tests++; if (got_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL full_data[%0d]: got %h expected %h", k, got_data[k], exp_d[k]); end
      n_tests++; if (got_last[k] != (k == 31)) begin n_fail++; $display("FAIL full_last[%0d]: got %b expected %b", k, got_last[k], k == 31); end
      n_tests++; if (got_cyc[k] != 2 * k + 2) begin n_fail++; $display("FAIL full_cycle[%0d]: got %0d expected %0d", k, got_cyc[k], 2 * k + 2); end
    end
    n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", done_cyc.size()); end
    else begin
      n_tests++; if (done_cyc[0] != 65) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected 65", done_cyc[0]); end
    end
    n_tests++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL full_done_busy_overlap: got %0d expected 0", overlap_cnt); end
    n_tests++; if (late_busy != 0) begin n_fail++; $display("FAIL full_after_done: got %0d expected 0", late_busy); end
  endtask

  task automatic test_backpressure();
    preload();
    run(0, 5'd0, 1, 1, 0, 0);
    n_tests++; if (got_idx.size() != 32 || timed_out) begin n_fail++; $display("FAIL bp_count: got %0d expected 32", got_idx.size()); end
    for (int k = 0; k < got_idx.size() && k < 32; k++) begin
      n_tests++; if (got_idx[k] != k || got_data[k] !== regs[k]) begin
        n_fail++; $display("FAIL bp_word[%0d]: got %0d/%h expected %0d/%h", k, got_idx[k], got_data[k], k, regs[k]);
      end
    end
    n_tests++; if (stall_d.size() != 5) begin n_fail++; $display("FAIL bp_stall_len: got %0d expected 5", stall_d.size()); end
    for (int s = 0; s < stall_d.size(); s++) begin
      n_tests++; if (stall_d[s] !== 32'h1000_0007 || stall_i[s] != 7 || stall_g[s] != 7) begin
        n_fail++; $display("FAIL bp_stall[%0d]: got data %h idx %0d dbg %0d expected 10000007/7/7", s, stall_d[s], stall_i[s], stall_g[s]);
      end
    end
    n_tests++; if (hold_cnt != 0) begin n_fail++; $display("FAIL bp_hold: got %0d changes expected 0", hold_cnt); end
    n_tests++; if (drop_cnt != 0) begin n_fail++; $display("FAIL bp_drop: got %0d drops expected 0", drop_cnt); end
  endtask

  task automatic test_single();
    preload();
    run(1, 5'd13, 0, 0, 0, 0);
    n_tests++; if (got_idx.size() != 1 || timed_out) begin n_fail++; $display("FAIL single_count: got %0d expected 1", got_idx.size()); end
    else begin
      n_tests++; if (got_idx[0] != 13) begin n_fail++; $display("FAIL single_idx: got %0d expected 13", got_idx[0]); end
      n_tests++; if (got_data[0] !== 32'h1000_000D) begin n_fail++; $display("FAIL single_data: got %h expected 1000000d", got_data[0]); end
      n_tests++; if (got_last[0] != 1) begin n_fail++; $display("FAIL single_last: got %b expected 1", got_last[0]); end
      n_tests++; if (got_cyc[0] != 2) begin n_fail++; $display("FAIL single_cycle: got %0d expected 2", got_cyc[0]); end
    end
    n_tests++; if (obs_dbg1 != 13) begin n_fail++; $display("FAIL single_dbg_c1: got %0d expected 13", obs_dbg1); end
    n_tests++; if (done_cyc.size() != 1 || done_cyc[0] != 3) begin
      n_fail++; $display("FAIL single_done: got %0d pulses expected 1 at cycle 3", done_cyc.size());
    end
  endtask

  task automatic test_start_while_busy();
    preload();
    run(0, 5'd0, 0, 0, 1, 0);
    n_tests++; if (got_idx.size() != 32 || timed_out) begin n_fail++; $display("FAIL swb_count: got %0d expected 32", got_idx.size()); end
    for (int k = 0; k < got_idx.size() && k < 32; k++) begin
      n_tests++; if (got_idx[k] != k) begin n_fail++; $display("FAIL swb_idx[%0d]: got %0d expected %0d", k, got_idx[k], k); end
    end
    n_tests++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL swb_done_count: got %0d expected 1", done_cyc.size()); end
    n_tests++; if (late_busy != 0) begin n_fail++; $display("FAIL swb_restart: got %0d busy cycles expected 0", late_busy); end
  endtask

  task automatic test_reset_mid_dump();
    bit found = 0;
    int dones = 0;
    preload();
    start = 1'b1; single = 1'b0; sel_reg = '0; out_if.ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (out_if.valid && out_if.index == 5'd10) begin found = 1; break; end
      step();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rst_mid_reach: got 0 expected 1"); end
    rst = 1'b1; out_if.ready = 1'b0;
    step();
    rst = 1'b0;
    n_tests++; if ({debug_input, out_if.valid, out_if.index, out_if.data, out_if.last, busy, done} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got dbg %0d v %b i %0d d %h l %b b %b dn %b expected all 0",
                         debug_input, out_if.valid, out_if.index, out_if.data, out_if.last, busy, done);
    end
    for (int c = 0; c < 6; c++) begin
      if (done || busy) dones++;
      step();
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d expected 0", dones); end
    run(0, 5'd0, 0, 0, 0, 0);
    n_tests++; if (got_idx.size() != 32 || got_idx[0] != 0) begin
      n_fail++; $display("FAIL rst_mid_restart: got %0d words expected 32 from index 0", got_idx.size());
    end
  endtask

  task automatic test_concurrent_write();
    preload();
    for (int i = 0; i < 32; i++) exp_d[i] = regs[i];
    exp_d[20] = 32'hDEAD_BEEF;
    run(0, 5'd0, 0, 0, 0, 1);
    n_tests++; if (got_idx.size() != 32 || timed_out) begin n_fail++; $display("FAIL cw_count: got %0d expected 32", got_idx.size()); end
    for (int k = 0; k < got_idx.size() && k < 32; k++) begin
      n_tests++; if (got_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL cw_data[%0d]: got %h expected %h", k, got_data[k], exp_d[k]); end
    end
  endtask

  task automatic test_random();
    logic [4:0] sel;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'h0;
    for (int i = 0; i < 32; i++) exp_d[i] = regs[i];
    run(0, 5'd0, 1, 0, 0, 0);
    n_tests++; if (got_idx.size() != 32 || timed_out) begin n_fail++; $display("FAIL rnd_count: got %0d expected 32", got_idx.size()); end
    for (int k = 0; k < got_idx.size() && k < 32; k++) begin
      n_tests++; if (got_idx[k] != k || got_data[k] !== exp_d[k] || got_last[k] != (k == 31)) begin
        n_fail++; $display("FAIL rnd_word[%0d]: got %0d/%h/%b expected %0d/%h/%b", k, got_idx[k], got_data[k], got_last[k], k, exp_d[k], k == 31);
      end
    end
    n_tests++; if (hold_cnt != 0 || drop_cnt != 0) begin n_fail++; $display("FAIL rnd_hold_drop: got %0d/%0d expected 0/0", hold_cnt, drop_cnt); end
    for (int r = 0; r < 4; r++) begin
      sel = 5'($urandom_range(0, 31));
      run(1, sel, 1, 0, 0, 0);
      n_tests++; if (got_idx.size() != 1 || got_idx[0] != int'(sel) || got_data[0] !== exp_d[sel] || !got_last[0]) begin
        n_fail++; $display("FAIL rnd_single[%0d]: got %0d words expected 1 word idx %0d data %h", r, got_idx.size(), sel, exp_d[sel]);
      end
    end
  endtask

  initial begin
    out_if.ready = 1'b0;
    preload();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_single();
    test_start_while_busy();
    test_reset_mid_dump();
    test_concurrent_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
